eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

Transmit framer between the Ethernet peripheral's TX byte buffer and a byte-wide MII/GMII-style PHY transmit port. On a start command it builds one frame on `txd`/`tx_en`:
- preamble and SFD;
- payload read from the buffer;
- zero padding up to the minimum frame size;
- CRC-32 FCS;
- enforced inter-frame gap.

It replaces the simulation-only send path of the peripheral with synthesizable transmission.

## Interface
- `MAX_LEN`, 1514: largest accepted payload length in bytes (destination, source and type fields included; FCS excluded).
- `MIN_LEN`, 60: payload is zero-padded up to this length before the FCS.
- `IFG`, 12: idle cycles after the last FCS byte.
- `ADDR_W`, 11: TX buffer address width.

Ports:
- `clk`  in  1  transmit clock; one byte per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `len`  in  16  payload length; sampled with `start`.
- `rd_addr`  out  ADDR_W  TX buffer read address.
- `rd_data`  in  8  TX buffer byte; valid one cycle after `rd_addr`.
- `txd`  out  8  byte to the PHY.
- `tx_en`  out  1  frame byte valid.
- `busy`  out  1  high from the cycle after an accepted `start` until the IFG completes.
- `done`  out  1  one-cycle pulse when the frame is complete.
- `err`  out  1  one-cycle pulse when a `start` is rejected.

## Operation
- States: IDLE → PRE → SFD → DATA → PAD → FCS → GAP → IDLE.
- IDLE: `start` is accepted when 1 ≤ `len` ≤ `MAX_LEN`.
  - The length is latched and the state moves to PRE.
  - If `len` is 0 or greater than `MAX_LEN`, `err` pulses the next cycle and the state stays IDLE.
- PRE: 7 cycles of `txd`=0x55.
- SFD: 1 cycle of `txd`=0xD5; `rd_addr`=0 is issued in this cycle.
- DATA: byte k has `txd`=`rd_data` and `rd_addr`=k+1. Leaves DATA after byte len−1.
- PAD: `txd`=0x00 until MIN_LEN bytes have been sent in total. Skipped if `len` ≥ `MIN_LEN`.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Computed over DATA and PAD bytes only.
  - The FCS is the complement of the final register, sent least-significant byte first over 4 cycles.
- GAP: `tx_en`=0 for `IFG` cycles, then IDLE.
- `done` pulses in the first GAP cycle.
- `start` is ignored whenever the state is not IDLE: no error, no queuing.
- `rd_addr` holds its last value outside SFD and DATA.
- Internal byte counter is 16 bits; it never wraps because `len` ≤ `MAX_LEN` < 65535.

## Timing
- Reset values: state IDLE, `txd`=0, `tx_en`=0, `busy`=0, `done`=0, `err`=0, `rd_addr`=0.
- Reset mid-frame: `tx_en` drops asynchronously. The frame is truncated, not completed, and no `done` is produced.
- `start` in cycle 0 gives:
  - first preamble byte with `tx_en`=1 in cycle 1;
  - SFD in cycle 8;
  - payload byte 0 in cycle 9.
- Cycle count:
  - `tx_en` is high for 8 + max(len, MIN_LEN) + 4 consecutive cycles.
  - `busy` stays high IFG cycles longer.
  - Earliest next accepted `start` is in the cycle after `busy` falls.
- `txd`, `tx_en`, `busy`, `done` and `err` are all registered; no combinational path from inputs.
- When `tx_en`=0, `txd` is 0.

## Structure
- Package `eth_pkg` holds:
  - constants ETH_PREAMBLE (0x55), ETH_SFD (0xD5), ETH_CRC_POLY, ETH_CRC_INIT, preamble count 7;
  - the state enum typedef.
- Sub-module `eth_crc32`: byte-wide CRC register with `clear` and `en` inputs, exposing the complemented value. It is reused by a future RX checker.

## Test plan
- `start` with `len`=60, all buffer bytes 0x00:
  - 0x55×7, 0xD5, 60×0x00, FCS;
  - `tx_en` high for exactly 72 cycles;
  - `done` one cycle after the last FCS byte; `busy` low 12 cycles later.
- Instance with MIN_LEN=0, buffer "123456789", `len`=9: FCS bytes are 0x26, 0x39, 0xF4, 0xCB.
- `len`=14 with MIN_LEN=60: 14 buffer bytes, then 46 bytes of 0x00, then FCS. `rd_addr` never exceeds 14.
- `len`=0 and `len`=1515: `err` pulses once, `tx_en` stays 0, `busy` stays 0.
- `start` pulsed during DATA and during GAP: ignored. A `start` one cycle after `busy` falls is accepted.
- `rst_n` asserted at payload byte 20: `tx_en`=0 immediately, no `done`. A new `start` after release produces a complete correct frame.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX constants, FSM state encoding and the byte-wide CRC-32 step.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;
  localparam int          ETH_PRE_CNT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_GAP
  } eth_state_e;

  // Reflected CRC-32: shifts out LSB first, one data byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register with synchronous clear; crc_out is the complemented
// register, i.e. the FCS value once the last byte has been absorbed.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = ETH_CRC_INIT;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= ETH_CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = ~crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble/SFD, buffer payload, zero pad, FCS, IFG.
// All PHY-side outputs are registered; the buffer is read with one cycle of access time.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1514,
  parameter int MIN_LEN = 60,
  parameter int IFG     = 12,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        txd,
  output logic              tx_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  eth_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        txd_q, txd_d;
  logic              tx_en_q, tx_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              len_ok;
  logic              last_data;
  logic              crc_clear;
  logic              crc_en;
  logic [31:0]       fcs;

  assign len_ok    = (len != 16'd0) && (len <= 16'(MAX_LEN));
  assign last_data = (cnt_q == len_q - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      rd_addr_q <= '0;
      txd_q     <= '0;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      rd_addr_q <= rd_addr_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // cnt_q indexes the byte currently on txd within its phase; DATA and PAD share it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: begin
        if (start && len_ok) begin
          state_d = ST_PRE;
          cnt_d   = '0;
          len_d   = len;
        end
      end
      ST_PRE: begin
        if (cnt_q == 16'(ETH_PRE_CNT - 1)) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SFD: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (last_data) begin
          if (len_q < 16'(MIN_LEN)) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_FCS;
            cnt_d   = '0;
          end
        end
      end
      ST_PAD: begin
        if (cnt_q == 16'(MIN_LEN - 1)) begin
          state_d = ST_FCS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_FCS: begin
        if (cnt_q == 16'd3) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 16'(IFG - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs describe the byte of the coming cycle, so they decode state_d/cnt_d.
  always_comb begin
    txd_d     = 8'h00;
    tx_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_d)
      ST_PRE: begin
        txd_d   = ETH_PREAMBLE;
        tx_en_d = 1'b1;
      end
      ST_SFD: begin
        txd_d     = ETH_SFD;
        tx_en_d   = 1'b1;
        rd_addr_d = '0;
      end
      ST_DATA: begin
        txd_d     = rd_data;
        tx_en_d   = 1'b1;
        rd_addr_d = ADDR_W'(cnt_d + 16'd1);
      end
      ST_PAD: tx_en_d = 1'b1;
      ST_FCS: begin
        txd_d   = fcs[{cnt_d[1:0], 3'b000} +: 8];
        tx_en_d = 1'b1;
      end
      default: ;
    endcase
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_FCS) && (state_d == ST_GAP);
    err_d     = (state_q == ST_IDLE) && start && !len_ok;
    crc_clear = (state_q == ST_IDLE) && (state_d == ST_PRE);
    crc_en    = (state_d == ST_DATA) || (state_d == ST_PAD);
  end

  eth_crc32 u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (crc_clear),
    .en      (crc_en),
    .data    (txd_d),
    .crc_out (fcs)
  );

  assign rd_addr = rd_addr_q;
  assign txd     = txd_q;
  assign tx_en   = tx_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: scoreboard of expected PHY bytes per instance, plus
// per-frame cycle accounting (tx_en length, done position, busy release).
module tb_eth_tx_framer;

  localparam int MIN_LEN = 60;
  localparam int IFG     = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0;
  logic [15:0] len_a = '0;
  logic [10:0] rd_addr_a;
  logic [7:0]  rd_data_a, txd_a;
  logic        tx_en_a, busy_a, done_a, err_a;

  logic        start_b = 1'b0;
  logic [15:0] len_b = '0;
  logic [10:0] rd_addr_b;
  logic [7:0]  rd_data_b, txd_b;
  logic        tx_en_b, busy_b, done_b, err_b;

  logic [7:0]  mem_a [0:2047];
  logic [7:0]  mem_b [0:2047];
  logic [7:0]  exp_a [$];
  logic [7:0]  exp_b [$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rd_data_a = mem_a[rd_addr_a];
  assign rd_data_b = mem_b[rd_addr_b];

  eth_tx_framer #(.MAX_LEN(1514), .MIN_LEN(MIN_LEN), .IFG(IFG), .ADDR_W(11)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .len(len_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .txd(txd_a), .tx_en(tx_en_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  eth_tx_framer #(.MAX_LEN(1514), .MIN_LEN(0), .IFG(IFG), .ADDR_W(11)) u_dut_nopad (
    .clk(clk), .rst_n(rst_n), .start(start_b), .len(len_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .txd(txd_b), .tx_en(tx_en_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      c = ((c[0] ^ b[k]) ? 32'hEDB88320 : 32'h0) ^ (c >> 1);
    end
    return c;
  endfunction

  // Monitors: every tx_en cycle pops one expected byte; idle cycles must show txd=0.
  always @(negedge clk) begin
    if (tx_en_a) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_extra_byte actual=%0h required=no byte", txd_a);
      end else begin
        chk("a_txd", {24'h0, txd_a}, {24'h0, exp_a.pop_front()});
      end
    end else begin
      chk("a_idle_txd", {24'h0, txd_a}, 32'h0);
    end
  end

  always @(negedge clk) begin
    if (tx_en_b) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_extra_byte actual=%0h required=no byte", txd_b);
      end else begin
        chk("b_txd", {24'h0, txd_b}, {24'h0, exp_b.pop_front()});
      end
    end
  end

  task automatic push_frame_a(input int len);
    logic [31:0] crc;
    logic [7:0]  b;
    int n;
    for (int i = 0; i < 7; i++) exp_a.push_back(8'h55);
    exp_a.push_back(8'hD5);
    crc = 32'hFFFFFFFF;
    n = (len < MIN_LEN) ? MIN_LEN : len;
    for (int i = 0; i < n; i++) begin
      b = (i < len) ? mem_a[i] : 8'h00;
      exp_a.push_back(b);
      crc = crc_step(crc, b);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) exp_a.push_back(crc[8*i +: 8]);
  endtask

  // Called at a negedge; start is high for the following clock edge (cycle 0).
  task automatic run_frame(input int len, input bit inject);
    int e, cyc, en_cnt, ndone, nerr, done_cyc, max_addr;
    e = 8 + ((len < MIN_LEN) ? MIN_LEN : len) + 4;
    push_frame_a(len);
    len_a = 16'(len);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    chk("first_pre_en_busy", {30'h0, tx_en_a, busy_a}, 32'h3);
    en_cnt = 0; ndone = 0; nerr = 0; done_cyc = 0; max_addr = 0;
    while (busy_a && cyc < 4000) begin
      if (tx_en_a) en_cnt++;
      if (done_a) begin ndone++; done_cyc = cyc; end
      if (err_a) nerr++;
      if (cyc >= 8 && int'(rd_addr_a) > max_addr) max_addr = int'(rd_addr_a);
      start_a = inject && (cyc == 20 || cyc == e + 3);
      len_a   = 16'd64;
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    chk("tx_en_cycles", en_cnt, e);
    chk("done_count", ndone, 1);
    chk("done_cycle", done_cyc, e + 1);
    chk("busy_fall_cycle", cyc, e + 1 + IFG);
    chk("err_during_frame", nerr, 0);
    chk("max_rd_addr", max_addr, len);
    chk("a_queue_left", exp_a.size(), 0);
  endtask

  task automatic run_err(input int len);
    int n;
    len_a = 16'(len);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("err_pulse", {31'h0, err_a}, 1);
    chk("err_busy", {31'h0, busy_a}, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (err_a) n++;
      chk("err_tx_en", {30'h0, tx_en_a, busy_a}, 0);
    end
    chk("err_single_pulse", n, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cnt, nd;
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_txd", {24'h0, txd_a}, 0);
    chk("rst_tx_en", {31'h0, tx_en_a}, 0);
    chk("rst_busy", {31'h0, busy_a}, 0);
    chk("rst_done", {31'h0, done_a}, 0);
    chk("rst_err", {31'h0, err_a}, 0);
    chk("rst_rd_addr", {21'h0, rd_addr_a}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Check value "123456789" on the unpadded instance.
    for (int i = 0; i < 9; i++) mem_b[i] = 8'(8'h31 + i);
    for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    for (int i = 0; i < 9; i++) exp_b.push_back(8'(8'h31 + i));
    exp_b.push_back(8'h26); exp_b.push_back(8'h39);
    exp_b.push_back(8'hF4); exp_b.push_back(8'hCB);
    len_b = 16'd9;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1; cnt = 0;
    while (busy_b && cyc < 200) begin
      if (tx_en_b) cnt++;
      @(negedge clk);
      cyc++;
    end
    chk("b_tx_en_cycles", cnt, 21);
    chk("b_busy_fall_cycle", cyc, 34);
    chk("b_queue_left", exp_b.size(), 0);

    run_frame(60, 1'b0);
    for (int i = 0; i < 2048; i++) mem_a[i] = 8'(i * 7 + 3);
    run_frame(14, 1'b0);
    run_frame(1, 1'b0);
    run_err(0);
    run_err(1515);
    for (int i = 0; i < 2048; i++) mem_a[i] = 8'(i ^ (i >> 3));
    run_frame(1514, 1'b0);
    run_frame(100, 1'b1);
    run_frame(61, 1'b0);

    // Reset asserted while payload byte 20 is on the wire.
    for (int i = 0; i < 2048; i++) mem_a[i] = 8'(8'hA0 + i);
    push_frame_a(60);
    len_a = 16'd60;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    while (cyc < 29) begin
      @(negedge clk);
      cyc++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx_en", {31'h0, tx_en_a}, 0);
    chk("midrst_busy", {31'h0, busy_a}, 0);
    chk("midrst_txd", {24'h0, txd_a}, 0);
    exp_a.delete();
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done_a) nd++;
    end
    chk("midrst_no_done", nd, 0);
    for (int i = 0; i < 2048; i++) mem_a[i] = 8'(8'h5A ^ i);
    run_frame(64, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
